// File: rtl/exec_unit_mc.sv
// Multi-cycle execute unit: single-cycle ALU/shift ops plus iterative MUL/DIV,
// valid/ready on both sides, registered result and flags for writeback.
module exec_unit_mc #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            opcode,
    input  logic                  am,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     reg_b,
    input  logic [DATA_W-1:0]     mem_b,
    input  logic [SHAMT_W-1:0]    shamt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   result,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  ac_flag,
    output logic                  parity_flag,
    output logic                  dz_err
);
    localparam logic [4:0] OP_MOV = 5'b00000, OP_ADD = 5'b00001, OP_SUB = 5'b00010,
                           OP_MUL = 5'b00011, OP_DIV = 5'b00100, OP_INC = 5'b00101,
                           OP_DEC = 5'b00110, OP_AND = 5'b00111, OP_OR  = 5'b01000,
                           OP_NOT = 5'b01001, OP_XOR = 5'b01010, OP_ASL = 5'b10000,
                           OP_ASR = 5'b10001, OP_LSL = 5'b10010, OP_LSR = 5'b10011,
                           OP_ROL = 5'b10100, OP_ROR = 5'b10101, OP_CMP = 5'b11001;
    localparam int CNT_W = $clog2(DATA_W);
    localparam int NSTEP = (1 << SHAMT_W) - 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t              state_reg;
    logic                in_ready_reg, out_valid_reg;
    logic [2*DATA_W-1:0] result_reg;
    logic                zero_reg, carry_reg, ac_reg, parity_reg, dz_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   acc_hi_reg, acc_lo_reg, opnd_reg;
    logic                is_div_reg;

    logic [DATA_W-1:0] src_u, src_b;
    assign src_u = am ? mem_b : op_a;
    assign src_b = am ? mem_b : reg_b;

    // Shifts/rotates walk one position per step so the carry is the last bit moved out.
    logic [DATA_W-1:0] sh_v;
    logic              sh_c;
    always_comb begin
        sh_v = src_u;
        sh_c = 1'b0;
        for (int i = 0; i < NSTEP; i++) begin
            if (i < int'(shamt)) begin
                case (opcode)
                    OP_ASL, OP_LSL: begin sh_c = sh_v[DATA_W-1]; sh_v = {sh_v[DATA_W-2:0], 1'b0}; end
                    OP_ASR: begin sh_c = sh_v[0]; sh_v = {sh_v[DATA_W-1], sh_v[DATA_W-1:1]}; end
                    OP_LSR: begin sh_c = sh_v[0]; sh_v = {1'b0, sh_v[DATA_W-1:1]}; end
                    OP_ROL: sh_v = {sh_v[DATA_W-2:0], sh_v[DATA_W-1]};
                    OP_ROR: sh_v = {sh_v[0], sh_v[DATA_W-1:1]};
                    default: ;
                endcase
            end
        end
    end

    logic [DATA_W:0]   add_w, sub_w;
    logic [DATA_W-1:0] lo1, hi1;
    logic              c1, ac1, dz1, iter_op;
    assign add_w = {1'b0, op_a} + {1'b0, src_b};
    assign sub_w = {1'b0, op_a} - {1'b0, src_b};
    assign iter_op = (opcode == OP_MUL) || ((opcode == OP_DIV) && (src_b != '0));

    always_comb begin
        lo1 = '0;
        hi1 = '0;
        c1  = 1'b0;
        ac1 = 1'b0;
        dz1 = 1'b0;
        case (opcode)
            OP_MOV: lo1 = src_u;
            OP_ADD: begin
                lo1 = add_w[DATA_W-1:0];
                c1  = add_w[DATA_W];
                ac1 = ({1'b0, op_a[3:0]} + {1'b0, src_b[3:0]}) > 5'd15;
            end
            OP_SUB: begin
                lo1 = sub_w[DATA_W-1:0];
                c1  = sub_w[DATA_W];
                ac1 = op_a[3:0] < src_b[3:0];
            end
            OP_DIV: begin
                // Only reached with a zero divisor; non-zero divisors iterate.
                lo1 = '1;
                hi1 = op_a;
                dz1 = 1'b1;
            end
            OP_INC: begin lo1 = src_u + DATA_W'(1); ac1 = &src_u[3:0]; end
            OP_DEC: begin
                lo1 = src_u - DATA_W'(1);
                c1  = (src_u == '0);
                ac1 = (src_u[3:0] == 4'd0);
            end
            OP_AND: lo1 = op_a & src_b;
            OP_OR:  lo1 = op_a | src_b;
            OP_NOT: lo1 = ~src_u;
            OP_XOR: lo1 = op_a ^ src_b;
            OP_ASL, OP_LSL, OP_ASR, OP_LSR, OP_ROL, OP_ROR: begin lo1 = sh_v; c1 = sh_c; end
            OP_CMP: lo1 = {{(DATA_W-1){1'b0}}, (op_a >= src_b)};
            default: ;
        endcase
    end

    // One iteration step: shift-add multiply or restoring divide on {acc_hi, acc_lo}.
    logic [DATA_W:0]   mul_sum, div_shift;
    logic [DATA_W-1:0] div_rem, step_hi, step_lo;
    logic              div_ge;
    assign mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
    assign div_shift = {acc_hi_reg, acc_lo_reg[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_reg};
    assign div_rem   = div_shift[DATA_W-1:0] - opnd_reg;
    assign step_hi   = is_div_reg ? (div_ge ? div_rem : div_shift[DATA_W-1:0]) : mul_sum[DATA_W:1];
    assign step_lo   = is_div_reg ? {acc_lo_reg[DATA_W-2:0], div_ge}
                                  : {mul_sum[0], acc_lo_reg[DATA_W-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            carry_reg     <= 1'b0;
            ac_reg        <= 1'b0;
            parity_reg    <= 1'b0;
            dz_reg        <= 1'b0;
            cnt_reg       <= '0;
            acc_hi_reg    <= '0;
            acc_lo_reg    <= '0;
            opnd_reg      <= '0;
            is_div_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: if (in_valid) begin
                    in_ready_reg <= 1'b0;
                    if (iter_op) begin
                        state_reg  <= S_ITER;
                        cnt_reg    <= CNT_W'(DATA_W - 1);
                        is_div_reg <= (opcode == OP_DIV);
                        acc_hi_reg <= '0;
                        acc_lo_reg <= (opcode == OP_DIV) ? op_a : src_b;
                        opnd_reg   <= (opcode == OP_DIV) ? src_b : op_a;
                    end else begin
                        state_reg     <= S_DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= {hi1, lo1};
                        zero_reg      <= (lo1 == '0);
                        carry_reg     <= c1;
                        ac_reg        <= ac1;
                        parity_reg    <= ^lo1;
                        dz_reg        <= dz1;
                    end
                end
                S_ITER: begin
                    acc_hi_reg <= step_hi;
                    acc_lo_reg <= step_lo;
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == '0) begin
                        state_reg     <= S_DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= {step_hi, step_lo};
                        // Division flags cover the quotient only; product flags cover all bits.
                        zero_reg      <= is_div_reg ? (step_lo == '0) : ({step_hi, step_lo} == '0);
                        parity_reg    <= is_div_reg ? ^step_lo : ^{step_hi, step_lo};
                        carry_reg     <= 1'b0;
                        ac_reg        <= 1'b0;
                        dz_reg        <= 1'b0;
                    end
                end
                S_DONE: if (out_ready) begin
                    state_reg     <= S_IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = out_valid_reg;
    assign result      = result_reg;
    assign zero_flag   = zero_reg;
    assign carry_flag  = carry_reg;
    assign ac_flag     = ac_reg;
    assign parity_flag = parity_reg;
    assign dz_err      = dz_reg;
endmodule

// File: tb/tb_exec_unit_mc.sv
// Randomized scoreboard bench for exec_unit_mc (DATA_W=8) against an arithmetic reference model.
module tb_exec_unit_mc;
    localparam int PERIOD = 10;
    localparam int HALF   = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic        am;
    logic [7:0]  op_a, reg_b, mem_b;
    logic [2:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        zero_flag, carry_flag, ac_flag, parity_flag, dz_err;

    exec_unit_mc #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .am(am), .op_a(op_a), .reg_b(reg_b), .mem_b(mem_b),
        .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .ac_flag(ac_flag),
        .parity_flag(parity_flag), .dz_err(dz_err)
    );

    always #HALF clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] res;
        logic [4:0]  flags;   // {zero, carry, ac, parity, dz}
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    bit          busy = 1'b0;
    bit          hold_active = 1'b0;
    logic [15:0] held_res = '0;
    logic [4:0]  held_flags = '0;
    logic [15:0] last_res = '0;
    logic [4:0]  last_flags = '0;
    int          rdy_mode = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic over 8-bit unsigned operands.
    function automatic exp_t model(input logic [4:0] op, input logic am_i, input logic [7:0] a,
                                   input logic [7:0] rb, input logic [7:0] mb, input logic [2:0] sh);
        exp_t e;
        int u, b, av, s, res, c, ac, dz, lat;
        bit wide;
        logic [15:0] r16;
        u = am_i ? int'(mb) : int'(a);
        b = am_i ? int'(mb) : int'(rb);
        av = int'(a);
        s = int'(sh);
        res = 0; c = 0; ac = 0; dz = 0; lat = 1; wide = 1'b0;
        case (op)
            5'd0:  res = u;
            5'd1:  begin res = av + b; c = res / 256; res = res % 256; ac = ((av % 16) + (b % 16)) > 15; end
            5'd2:  begin c = av < b; res = (av - b + 256) % 256; ac = (av % 16) < (b % 16); end
            5'd3:  begin res = av * b; wide = 1'b1; lat = 9; end
            5'd4:  if (b == 0) begin res = av * 256 + 255; dz = 1; end
                   else begin res = (av % b) * 256 + av / b; lat = 9; end
            5'd5:  begin res = (u + 1) % 256; ac = (u % 16) == 15; end
            5'd6:  begin res = (u + 255) % 256; c = (u == 0); ac = (u % 16) == 0; end
            5'd7:  res = av & b;
            5'd8:  res = av | b;
            5'd9:  res = 255 - u;
            5'd10: res = av ^ b;
            5'd16, 5'd18: begin res = (u << s) % 256; c = (s == 0) ? 0 : (u >> (8 - s)) % 2; end
            5'd17: begin
                res = (((u >= 128) ? u - 256 : u) >>> s) & 255;
                c = (s == 0) ? 0 : (u >> (s - 1)) % 2;
            end
            5'd19: begin res = u >> s; c = (s == 0) ? 0 : (u >> (s - 1)) % 2; end
            5'd20: res = ((u << s) | (u >> (8 - s))) & 255;
            5'd21: res = ((u >> s) | (u << (8 - s))) & 255;
            5'd25: res = (av >= b) ? 1 : 0;
            default: res = 0;
        endcase
        r16 = 16'(res);
        e.op  = op;
        e.res = r16;
        e.flags[4] = wide ? (r16 == 16'd0) : (r16[7:0] == 8'd0);
        e.flags[3] = c[0];
        e.flags[2] = ac[0];
        e.flags[1] = wide ? ^r16 : ^r16[7:0];
        e.flags[0] = dz[0];
        e.lat   = lat;
        e.t_acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [4:0] op, input logic am_i, input logic [7:0] a,
                         input logic [7:0] rb, input logic [7:0] mb, input logic [2:0] sh);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 200 cycles");
                return;
            end
        end
        opcode = op; am = am_i; op_a = a; reg_b = rb; mem_b = mb; shamt = sh;
        in_valid = 1'b1;
        @(posedge clk);
        e = model(op, am_i, a, rb, mb, sh);
        e.t_acc = longint'($time);
        q.push_back(e);
        busy = 1'b1;
        #1;
        // A command presented while busy must be ignored.
        if ($urandom_range(0, 1) == 1) begin
            opcode = 5'($urandom_range(0, 31)); op_a = 8'($urandom); reg_b = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: compares each presented result with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        int lat;
        if (!reset) begin
            check("in_ready", 32'(in_ready), 32'(!busy));
            if (out_valid) begin
                if (!hold_active) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: result 0x%0h with empty scoreboard", result);
                    end else begin
                        e = q.pop_front();
                        lat = int'((longint'($time) - e.t_acc + HALF) / PERIOD);
                        check("latency", 32'(lat), 32'(e.lat));
                        check("result", 32'(result), 32'(e.res));
                        check("flags", 32'({zero_flag, carry_flag, ac_flag, parity_flag, dz_err}), 32'(e.flags));
                        $display("txn op=%05b result=0x%04h flags(z,c,ac,p,dz)=%05b lat=%0d",
                                 e.op, result, {zero_flag, carry_flag, ac_flag, parity_flag, dz_err}, lat);
                    end
                    hold_active = 1'b1;
                    held_res   = result;
                    held_flags = {zero_flag, carry_flag, ac_flag, parity_flag, dz_err};
                end else begin
                    check("hold_result", 32'(result), 32'(held_res));
                    check("hold_flags", 32'({zero_flag, carry_flag, ac_flag, parity_flag, dz_err}), 32'(held_flags));
                end
                if (out_ready) begin
                    hold_active = 1'b0;
                    busy        = 1'b0;
                    last_res    = held_res;
                    last_flags  = held_flags;
                end
            end else begin
                check("idle_result", 32'(result), 32'(last_res));
                check("idle_flags", 32'({zero_flag, carry_flag, ac_flag, parity_flag, dz_err}), 32'(last_flags));
            end
        end
    end

    localparam int NVALID = 18;
    logic [4:0] valid_ops [NVALID] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                       5'd9, 5'd10, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd25};

    initial begin
        logic [4:0] op;
        logic [7:0] rb, mb;
        int n;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; am = 1'b0; op_a = '0; reg_b = '0; mem_b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({zero_flag, carry_flag, ac_flag, parity_flag, dz_err}), 32'd0);
        reset = 1'b0;

        // Directed cases
        rdy_mode = 1;
        issue(5'b00001, 1'b0, 8'hFF, 8'h01, 8'h00, 3'd0);   // ADD wrap
        issue(5'b00011, 1'b0, 8'hFF, 8'hFF, 8'h00, 3'd0);   // MUL max
        issue(5'b00100, 1'b1, 8'd200, 8'd0, 8'd7, 3'd0);    // DIV via mem_b
        issue(5'b00100, 1'b0, 8'd200, 8'd0, 8'd7, 3'd0);    // DIV by zero
        issue(5'b10001, 1'b0, 8'h81, 8'h00, 8'h00, 3'd2);   // ASR
        issue(5'b10011, 1'b0, 8'h81, 8'h00, 8'h00, 3'd1);   // LSR
        issue(5'b10100, 1'b0, 8'h81, 8'h00, 8'h00, 3'd1);   // ROL
        issue(5'b10000, 1'b0, 8'h81, 8'h00, 8'h00, 3'd0);   // shift by 0
        issue(5'b00110, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0);   // DEC borrow
        issue(5'b11001, 1'b0, 8'h10, 8'h10, 8'h00, 3'd0);   // CMP equal
        issue(5'b11111, 1'b0, 8'h12, 8'h34, 8'h56, 3'd3);   // undefined op
        drain();

        // Backpressure: consumer stalls three cycles after an ADD
        rdy_mode = 2;
        issue(5'b00001, 1'b0, 8'h0F, 8'h01, 8'h00, 3'd0);
        repeat (3) @(posedge clk);
        rdy_mode = 1;
        drain();

        // Reset in the middle of a multiply
        issue(5'b00011, 1'b0, 8'h37, 8'hA5, 8'h00, 3'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        q.delete();
        busy = 1'b0; hold_active = 1'b0; last_res = '0; last_flags = '0;
        @(posedge clk);
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({zero_flag, carry_flag, ac_flag, parity_flag, dz_err}), 32'd0);
        reset = 1'b0;
        issue(5'b00001, 1'b0, 8'h21, 8'h12, 8'h00, 3'd0);
        drain();

        // Randomized traffic with random consumer backpressure
        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            n = $urandom_range(0, NVALID + 1);
            op = (n < NVALID) ? valid_ops[n] : 5'($urandom_range(0, 31));
            rb = 8'($urandom);
            mb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            if ($urandom_range(0, 7) == 0) mb = 8'd0;
            issue(op, 1'($urandom_range(0, 1)), 8'($urandom), rb, mb, 3'($urandom_range(0, 7)));
        end
        rdy_mode = 1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
